// File: rtl/rw_responder.sv
// rw_responder
//
// Target-side responder for a single-cycle read/write strobe protocol.
// Write and read strobes are decoded into a small register file. Each
// accepted request is answered with a one-cycle `ready` pulse: one cycle
// after a write, READ_LAT cycles after a read, with read data alongside.
// Protocol violations set a sticky error flag. These violations are
// simultaneous strobes, and any strobe while a read is outstanding.
//
// Parameters
//   AW        address width; the register file holds 2**AW words
//   DW        data width
//   READ_LAT  read latency in cycles, 1..4
//
// Ports
//   clock   in   rising-edge clock
//   resetn  in   synchronous reset, active-low; clears state and memory
//   read    in   read strobe
//   write   in   write strobe
//   addr    in   request address [AW-1:0]
//   wdata   in   write data [DW-1:0]
//   ready   out  registered one-cycle acknowledge
//   rdata   out  read data [DW-1:0], valid with ready after a read, held otherwise
//   busy    out  a read is outstanding and not yet acknowledged
//   err     out  sticky protocol-error flag, cleared only by reset

module rw_responder #(
  parameter int AW       = 2,
  parameter int DW       = 8,
  parameter int READ_LAT = 2
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          read,
  input  logic          write,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          err
);

  localparam int DEPTH = 1 << AW;

  // Value loaded into the wait counter when a multi-cycle read is accepted.
  // The read completes on the edge where the counter reads 1. A 2-bit
  // counter therefore covers every latency up to 4 without wrapping.
  localparam logic [1:0] CNT_LOAD = 2'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RWAIT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [AW-1:0] raddr;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 2'd0;
      raddr <= '0;
      ready <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ready <= 1'b0;
      case (state)
        // IDLE and ACK both accept a new request. This allows
        // back-to-back traffic in the acknowledge cycle.
        IDLE, ACK: begin
          if (read && write) begin
            // Simultaneous strobes: no access. In IDLE, the state stays
            // unchanged. In ACK, the state drops to IDLE so that no
            // second pulse follows.
            err   <= 1'b1;
            state <= IDLE;
          end else if (write) begin
            mem[addr] <= wdata;
            ready     <= 1'b1;
            state     <= ACK;
          end else if (read) begin
            raddr <= addr;
            if (READ_LAT == 1) begin
              rdata <= mem[addr];
              ready <= 1'b1;
              state <= ACK;
            end else begin
              cnt   <= CNT_LOAD;
              state <= RWAIT;
            end
          end else begin
            state <= IDLE;
          end
        end

        RWAIT: begin
          // A strobe that arrives while the read is pending is dropped, not
          // queued. The pending read still finishes on schedule.
          if (read || write) begin
            err <= 1'b1;
          end
          if (cnt == 2'd1) begin
            rdata <= mem[raddr];
            ready <= 1'b1;
            state <= ACK;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Decoded straight from the state register, so it is still a registered
  // output with no path from the request inputs.
  assign busy = (state == RWAIT);

endmodule

// File: tb/tb_rw_responder.sv
// Testbench for rw_responder.
// Three instances run side by side with READ_LAT = 2, 1 and 3 (d0, d1, d2).
// Every request that should be acknowledged pushes an entry into that
// instance's scoreboard queue. The entry holds the cycle in which ready must
// appear and, for reads, the expected data. A monitor pops the entry
// whenever ready is seen. It flags any ready that arrives unexpected, early
// or late, and any expected ready that never arrives. Directed checks cover
// busy, err, held rdata and reset values.

module tb_rw_responder;

  logic       clock = 1'b0;
  logic       resetn;
  logic       rd  [3];
  logic       wr  [3];
  logic [1:0] ad  [3];
  logic [7:0] wd  [3];
  logic       rdy [3];
  logic [7:0] rdt [3];
  logic       bsy [3];
  logic       er  [3];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    bit         chk;
    logic [7:0] data;
  } exp_t;

  exp_t sbq [3][$];

  always #5 clock = ~clock;

  // Counts rising edges. After edge N, cyc == N.
  always @(posedge clock) cyc <= cyc + 1;

  rw_responder #(.AW(2), .DW(8), .READ_LAT(2)) u_d0 (
    .clock(clock), .resetn(resetn), .read(rd[0]), .write(wr[0]),
    .addr(ad[0]), .wdata(wd[0]), .ready(rdy[0]), .rdata(rdt[0]),
    .busy(bsy[0]), .err(er[0]));

  rw_responder #(.AW(2), .DW(8), .READ_LAT(1)) u_d1 (
    .clock(clock), .resetn(resetn), .read(rd[1]), .write(wr[1]),
    .addr(ad[1]), .wdata(wd[1]), .ready(rdy[1]), .rdata(rdt[1]),
    .busy(bsy[1]), .err(er[1]));

  rw_responder #(.AW(2), .DW(8), .READ_LAT(3)) u_d2 (
    .clock(clock), .resetn(resetn), .read(rd[2]), .write(wr[2]),
    .addr(ad[2]), .wdata(wd[2]), .ready(rdy[2]), .rdata(rdt[2]),
    .busy(bsy[2]), .err(er[2]));

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_d(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clock) begin
    for (int d = 0; d < 3; d++) begin
      if (rdy[d] === 1'b1) begin
        if (sbq[d].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL d%0d_unexpected_ready: got ready=1 at cycle %0d, expected ready=0", d, cyc);
        end else begin
          exp_t e;
          e = sbq[d].pop_front();
          check_i($sformatf("d%0d_ack_cycle", d), cyc, e.cyc);
          if (e.chk) check_d($sformatf("d%0d_rdata", d), rdt[d], e.data);
        end
      end else if (sbq[d].size() != 0 && sbq[d][0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL d%0d_missed_ready: got none by cycle %0d, expected at cycle %0d", d, cyc, sbq[d][0].cyc);
        void'(sbq[d].pop_front());
      end
    end
  end

  task automatic clear_strobes();
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0;
      wr[i] = 1'b0;
    end
  endtask

  // Drive a request now, without waiting for an edge. lat is the number of
  // edges until ready is visible (0 = no acknowledge expected).
  task automatic issue(input int d, input logic r, input logic w, input logic [1:0] a,
                       input logic [7:0] dat, input int lat, input logic [7:0] exp);
    exp_t e;
    rd[d] = r;
    wr[d] = w;
    ad[d] = a;
    wd[d] = dat;
    if (lat > 0) begin
      e.cyc  = cyc + lat;
      e.chk  = r;
      e.data = exp;
      sbq[d].push_back(e);
    end
  endtask

  task automatic req(input int d, input logic r, input logic w, input logic [1:0] a,
                     input logic [7:0] dat, input int lat, input logic [7:0] exp);
    @(negedge clock);
    clear_strobes();
    issue(d, r, w, a, dat, lat, exp);
  endtask

  task automatic tick();
    @(negedge clock);
    clear_strobes();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = 2'd0; wd[i] = 8'd0;
    end
    repeat (3) tick();

    // Reset state of all three instances
    for (int d = 0; d < 3; d++) begin
      check_b($sformatf("d%0d_reset_ready", d), rdy[d], 1'b0);
      check_b($sformatf("d%0d_reset_busy", d), bsy[d], 1'b0);
      check_b($sformatf("d%0d_reset_err", d), er[d], 1'b0);
      check_d($sformatf("d%0d_reset_rdata", d), rdt[d], 8'h00);
    end

    // Write addr1=0xA5 on the first edge with resetn high
    resetn = 1'b1;
    issue(0, 1'b0, 1'b1, 2'd1, 8'hA5, 1, 8'h00);
    tick();
    check_b("d0_write_err", er[0], 1'b0);
    tick();
    check_b("d0_write_ready_low", rdy[0], 1'b0);

    // READ_LAT=2 read of addr1
    req(0, 1'b1, 1'b0, 2'd1, 8'h00, 2, 8'hA5);
    tick();
    check_b("d0_read_busy", bsy[0], 1'b1);
    check_b("d0_read_ready_early", rdy[0], 1'b0);
    tick();
    check_b("d0_read_busy_ack", bsy[0], 1'b0);
    tick();
    check_b("d0_ready_after_read", rdy[0], 1'b0);
    check_d("d0_rdata_hold", rdt[0], 8'hA5);

    // READ_LAT=1: four back-to-back writes, then four back-to-back reads
    for (int a = 0; a < 4; a++) req(1, 1'b0, 1'b1, 2'(a), 8'(8'h10 + a), 1, 8'h00);
    for (int a = 0; a < 4; a++) req(1, 1'b1, 1'b0, 2'(a), 8'h00, 1, 8'(8'h10 + a));
    tick();
    tick();

    // Read in the acknowledge cycle of a write to the same address
    req(1, 1'b0, 1'b1, 2'd2, 8'h77, 1, 8'h00);
    req(1, 1'b1, 1'b0, 2'd2, 8'h00, 1, 8'h77);
    tick();
    tick();

    // Both strobes in the acknowledge cycle: no second pulse, no write
    req(1, 1'b0, 1'b1, 2'd0, 8'h55, 1, 8'h00);
    req(1, 1'b1, 1'b1, 2'd0, 8'h66, 0, 8'h00);
    tick();
    check_b("d1_both_in_ack_err", er[1], 1'b1);
    check_b("d1_both_in_ack_ready", rdy[1], 1'b0);
    req(1, 1'b1, 1'b0, 2'd0, 8'h00, 1, 8'h55);
    tick();
    tick();

    // Both strobes from IDLE: err sticks, memory untouched
    req(0, 1'b1, 1'b1, 2'd3, 8'hFF, 0, 8'h00);
    tick();
    check_b("d0_both_err", er[0], 1'b1);
    check_b("d0_both_ready", rdy[0], 1'b0);
    tick();
    check_b("d0_both_err_sticky", er[0], 1'b1);
    req(0, 1'b1, 1'b0, 2'd3, 8'h00, 2, 8'h00);
    repeat (3) tick();
    check_b("d0_err_still_set", er[0], 1'b1);

    // READ_LAT=3: a write during RWAIT is rejected; the read returns old data
    req(2, 1'b0, 1'b1, 2'd1, 8'h3C, 1, 8'h00);
    tick();
    req(2, 1'b1, 1'b0, 2'd1, 8'h00, 3, 8'h3C);
    req(2, 1'b0, 1'b1, 2'd1, 8'hEE, 0, 8'h00);
    tick();
    check_b("d2_rwait_write_err", er[2], 1'b1);
    check_b("d2_rwait_busy", bsy[2], 1'b1);
    check_b("d2_rwait_ready", rdy[2], 1'b0);
    tick();
    tick();
    req(2, 1'b1, 1'b0, 2'd1, 8'h00, 3, 8'h3C);
    repeat (4) tick();

    // Reset during RWAIT: the pending read is dropped, state and memory clear
    req(2, 1'b1, 1'b0, 2'd1, 8'h00, 0, 8'h00);
    tick();
    resetn = 1'b0;
    tick();
    check_b("d2_midread_reset_ready", rdy[2], 1'b0);
    check_b("d2_midread_reset_busy", bsy[2], 1'b0);
    check_b("d2_midread_reset_err", er[2], 1'b0);
    check_d("d2_midread_reset_rdata", rdt[2], 8'h00);
    check_b("d0_reset_clears_err", er[0], 1'b0);
    resetn = 1'b1;
    req(2, 1'b1, 1'b0, 2'd1, 8'h00, 3, 8'h00);
    issue(1, 1'b1, 1'b0, 2'd2, 8'h00, 1, 8'h00);
    issue(0, 1'b1, 1'b0, 2'd1, 8'h00, 2, 8'h00);
    repeat (6) tick();

    for (int d = 0; d < 3; d++) check_i($sformatf("d%0d_scoreboard_drained", d), sbq[d].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rw_responder.md
# rw_responder

Target-side responder for the single-cycle read/write strobe protocol driven by the `demo` controller. It decodes mutually exclusive `read`/`write` strobes into a small register file and returns a one-cycle `ready` acknowledge: exactly one cycle after a write, and `READ_LAT` cycles after a read, with read data alongside. It also detects protocol violations: simultaneous strobes, and requests issued while a read is outstanding. It forms the far end of the controller under SVA checks, so the `!(read && write)` and `write |=> ready` properties hold as observable behaviour at this port.

## Interface
Parameters:
- `AW`, 2: address width; the register file holds 2^AW words.
- `DW`, 8: data width.
- `READ_LAT`, 2: read latency in cycles; legal range 1..4.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous reset, active-low.
- `read`  in  1  read strobe, sampled at each rising edge.
- `write`  in  1  write strobe, sampled at each rising edge.
- `addr`  in  AW  request address.
- `wdata`  in  DW  write data.
- `ready`  out  1  registered one-cycle acknowledge pulse.
- `rdata`  out  DW  read data; valid while `ready` is high after a read, held otherwise.
- `busy`  out  1  high while a read is outstanding and its acknowledge has not yet been given.
- `err`  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, RWAIT, ACK.
- An accepting state is IDLE or ACK. Back-to-back requests are allowed in the ACK cycle.
- Write (`write`=1, `read`=0) in an accepting state:
  - `mem[addr]` <= `wdata` at that edge.
  - Next state ACK; `ready`=1 in the following cycle.
  - `rdata` unchanged.
- Read (`read`=1, `write`=0) in an accepting state:
  - Latch `addr`.
  - If `READ_LAT`==1: `rdata` <= `mem[addr]`, next state ACK.
  - Otherwise: load down-counter with `READ_LAT`-1, next state RWAIT.
- RWAIT: decrement the counter each cycle. When it reaches 1, load `rdata` from the latched address and go to ACK.
  - The counter is 2 bits wide for `READ_LAT`<=4; no wrap is possible.
- ACK: `ready`=1 for exactly one cycle.
  - With no new request, next state IDLE.
  - A new legal request is processed as if from IDLE.
- Violations:
  - `read` && `write` in any state: no memory access, `err` <= 1, state unchanged. In ACK, go to IDLE instead.
  - Any strobe while in RWAIT: the request is ignored and `err` <= 1; the pending read completes normally.
- `busy` = (state == RWAIT), decoded from the state register.
- `err` clears only on reset.
- A read issued in the ACK cycle of a write to the same address returns the newly written data.
- Reset (`resetn`=0 at an edge), including mid-read:
  - State IDLE; any pending read is dropped with no `ready`.
  - `ready`=0, `busy`=0, `err`=0, `rdata`=0.
  - All `mem` words = 0.

## Timing
- Write sampled at edge N: `ready` high during cycle N+1, low at N+2 unless another request follows.
- Read sampled at edge N: `ready`=1 and `rdata` valid during cycle N+`READ_LAT`. `busy` is high for cycles N+1 .. N+`READ_LAT`-1.
- Maximum throughput is one write per cycle: continuous writes hold `ready` high continuously.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The first request after `resetn` rises is accepted at the first edge with `resetn`=1.

## Test plan
- Reset, then write addr 1 = 0xA5 at edge N: `ready`=1 only in cycle N+1, `err`=0.
- With `READ_LAT`=2, read addr 1 at edge N: `busy`=1 in N+1; `ready`=1 and `rdata`=0xA5 in N+2; `rdata` holds 0xA5 afterwards.
- Four consecutive writes (addr 0..3, data 0x10..0x13) then four reads with `READ_LAT`=1: `ready` high for four cycles after the writes, and `rdata` returns 0x10..0x13 in order.
- `read`=`write`=1 at edge N: no memory change, `ready` stays 0, `err`=1 from N+1 and stays 1 until reset.
- With `READ_LAT`=3, a write issued during RWAIT: `err`=1, memory unchanged, and the pending read still acknowledges at N+3 with the old data.
- `resetn` asserted low during RWAIT: no `ready` pulse, all outputs 0 next cycle, and a subsequent read of any address returns 0.
